// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and widths for the unified-memory arbiter.
// Contents: FSM state enum, transaction owner enum, address/data widths.
// Used by: mem_arbiter (top) and arb_pick (winner select).
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between fetch and data requests.
// Ports: if_req/d_req (requests), streak_sat (data streak at its limit),
//        any_req (someone is asking), winner (who gets the next access).
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  logic   streak_sat,
  output logic   any_req,
  output owner_t winner
);

  assign any_req = if_req | d_req;

  // Data wins unless fetch is also waiting and data has used up its streak.
  assign winner = (d_req && !(if_req && streak_sat)) ? OWN_D : OWN_IF;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU fetch and data accesses onto one fixed-latency
// single-port memory, data-priority with a fetch-starvation guard.
// Ports: if_* fetch port, d_* data port (req/grant/valid handshake),
//        mem_* memory port, busy = FSM not idle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t              state;
  owner_t              owner;
  owner_t              winner;
  logic                any_req;
  logic                lat_we;
  logic [STREAK_W-1:0] streak;
  logic [CNT_W-1:0]    cnt;
  logic                streak_sat;

  assign streak_sat = (streak == STREAK_W'(MAX_DATA_STREAK));
  assign busy       = (state != IDLE);

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .streak_sat (streak_sat),
    .any_req    (any_req),
    .winner     (winner)
  );

  // The mem_addr/mem_wdata registers double as the latched request for the
  // ISSUE cycle; the owner's rdata register is the response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_we    <= 1'b0;
      streak    <= '0;
      cnt       <= '0;
      if_grant  <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_grant   <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Grants, valids and the memory strobe are single-cycle pulses.
      if_grant  <= 1'b0;
      d_grant   <= 1'b0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= ISSUE;
            owner  <= winner;
            mem_en <= 1'b1;
            if (winner == OWN_D) begin
              lat_we    <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              d_grant   <= 1'b1;
              // Streak only grows while fetch is actually being held off.
              if (!if_req)         streak <= '0;
              else if (!streak_sat) streak <= streak + 1'b1;
            end else begin
              lat_we   <= 1'b0;
              mem_addr <= if_addr;
              if_grant <= 1'b1;
              streak   <= '0;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CNT_W'(MEM_LATENCY - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= lat_we ? '0 : mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
